// File: rtl/neuron_controller.sv
// neuron_controller -- sequencing FSM for one neuron datapath evaluation.
//
// On start the accumulator is cleared for one cycle, the N inputs are then
// loaded with offset stepping 0..N-1, the activation stage is enabled for one
// cycle, and the activation result is captured and held under a valid/ack
// handshake until the consumer takes it.
//
// Optional feature: define NEURON_CTRL_ABORT_EN to add an abort input that
// cancels an evaluation in progress (CLEAR/ACC/ACT) and returns to IDLE.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   abort       (NEURON_CTRL_ABORT_EN only) cancel the running evaluation
//   start       request one evaluation (honoured in IDLE, and in HOLD with out_ack)
//   hidden_in   layer type for the requested evaluation (1 = hidden layer)
//   result_in   activation output from the datapath
//   out_ack     consumer accepts result_out
//   acc_clr     accumulator clear strobe to the datapath
//   ld          accumulator load enable to the datapath
//   offset      input element select, 0..N-1
//   ready       activation enable to the datapath
//   hidden      layer type latched at start
//   busy        evaluation in progress (CLEAR/ACC/ACT)
//   out_valid   result_out holds an unacknowledged result
//   result_out  captured neuron result

module neuron_controller #(
    parameter int unsigned N  = 10,
    parameter int unsigned DW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef NEURON_CTRL_ABORT_EN
    input  logic                 abort,
`endif
    input  logic                 start,
    input  logic                 hidden_in,
    input  logic [DW-1:0]        result_in,
    input  logic                 out_ack,
    output logic                 acc_clr,
    output logic                 ld,
    output logic [$clog2(N)-1:0] offset,
    output logic                 ready,
    output logic                 hidden,
    output logic                 busy,
    output logic                 out_valid,
    output logic [DW-1:0]        result_out
);

    localparam int unsigned OW = $clog2(N);
    localparam logic [OW-1:0] LAST_OFFSET = OW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACC   = 3'd2,
        S_ACT   = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic          abort_hit;
    logic          acc_clr_d;
    logic          ld_d;
    logic          ready_d;
    logic          busy_d;
    logic          out_valid_d;
    logic          hidden_d;
    logic [OW-1:0] offset_d;
    logic [DW-1:0] result_d;

    // Abort only matters while an evaluation is actually running.
`ifdef NEURON_CTRL_ABORT_EN
    assign abort_hit = abort &&
                       ((state == S_CLEAR) || (state == S_ACC) || (state == S_ACT));
`else
    assign abort_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides every normal transition.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_CLEAR;
            S_CLEAR: state_next = S_ACC;
            S_ACC:   if (offset == LAST_OFFSET) state_next = S_ACT;
            S_ACT:   state_next = S_HOLD;
            S_HOLD: begin
                // Without out_ack the held result is protected: start is ignored.
                if (out_ack) begin
                    state_next = start ? S_CLEAR : S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (abort_hit) begin
            state_next = S_IDLE;
        end
    end

    // Output logic: values the output registers take at the next edge,
    // decoded from the upcoming state so every output is a flop.
    always_comb begin
        acc_clr_d   = (state_next == S_CLEAR);
        ld_d        = (state_next == S_ACC);
        ready_d     = (state_next == S_ACT);
        busy_d      = (state_next == S_CLEAR) || (state_next == S_ACC) ||
                      (state_next == S_ACT);
        out_valid_d = (state_next == S_HOLD);
        hidden_d    = hidden;
        result_d    = result_out;
        offset_d    = '0;

        // Offset advances only while staying in ACC; otherwise it parks at 0.
        if ((state == S_ACC) && (state_next == S_ACC)) begin
            offset_d = offset + OW'(1);
        end

        // CLEAR is only ever entered from IDLE or HOLD, i.e. on an accepted start.
        if (state_next == S_CLEAR) begin
            hidden_d = hidden_in;
        end

        // Capture at the closing edge of the activation cycle (not on abort).
        if ((state == S_ACT) && (state_next == S_HOLD)) begin
            result_d = result_in;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_clr    <= 1'b0;
            ld         <= 1'b0;
            ready      <= 1'b0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            hidden     <= 1'b0;
            offset     <= '0;
            result_out <= '0;
        end else begin
            acc_clr    <= acc_clr_d;
            ld         <= ld_d;
            ready      <= ready_d;
            busy       <= busy_d;
            out_valid  <= out_valid_d;
            hidden     <= hidden_d;
            offset     <= offset_d;
            result_out <= result_d;
        end
    end

endmodule

// File: tb/tb_neuron_controller.sv
// tb_neuron_controller -- directed self-checking bench for neuron_controller
// (N=10, DW=8). Each task drives one scenario and checks against hand-computed
// values. Build with NEURON_CTRL_ABORT_EN defined to include the abort scenario.

module tb_neuron_controller;

    localparam int unsigned N  = 10;
    localparam int unsigned DW = 8;
    localparam int unsigned OW = $clog2(N);

    logic          clk;
    logic          rst;
`ifdef NEURON_CTRL_ABORT_EN
    logic          abort;
`endif
    logic          start;
    logic          hidden_in;
    logic [DW-1:0] result_in;
    logic          out_ack;
    logic          acc_clr;
    logic          ld;
    logic [OW-1:0] offset;
    logic          ready;
    logic          hidden;
    logic          busy;
    logic          out_valid;
    logic [DW-1:0] result_out;

    int passed;
    int total;

    neuron_controller #(.N(N), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef NEURON_CTRL_ABORT_EN
        .abort      (abort),
`endif
        .start      (start),
        .hidden_in  (hidden_in),
        .result_in  (result_in),
        .out_ack    (out_ack),
        .acc_clr    (acc_clr),
        .ld         (ld),
        .offset     (offset),
        .ready      (ready),
        .hidden     (hidden),
        .busy       (busy),
        .out_valid  (out_valid),
        .result_out (result_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        total++; if ({acc_clr, ld, ready, busy, out_valid} !== 5'b0)
            $display("FAIL reset_flags got=%b exp=00000", {acc_clr, ld, ready, busy, out_valid});
        else passed++;
        total++; if (offset !== OW'(0)) $display("FAIL reset_offset got=%0d exp=0", offset);
        else passed++;
        total++; if (hidden !== 1'b0) $display("FAIL reset_hidden got=%b exp=0", hidden);
        else passed++;
        total++; if (result_out !== 8'h00) $display("FAIL reset_result got=%h exp=00", result_out);
        else passed++;
        step();
        rst = 1'b0;
        step();
    endtask

    // Asynchronous reset in the middle of ACC discards the evaluation.
    task automatic test_reset_mid_acc();
        bit late_valid;
        hidden_in = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        total++; if (!(ld === 1'b1 && offset === OW'(2)))
            $display("FAIL pre_reset_acc ld=%b off=%0d exp ld=1 off=2", ld, offset);
        else passed++;
        #3;
        rst = 1'b1;
        #1;
        total++; if ({acc_clr, ld, ready, busy, out_valid, hidden} !== 6'b0 || offset !== OW'(0))
            $display("FAIL async_reset flags=%b off=%0d exp all 0",
                     {acc_clr, ld, ready, busy, out_valid, hidden}, offset);
        else passed++;
        step();
        rst = 1'b0;
        late_valid = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            step();
            if (out_valid !== 1'b0 || busy !== 1'b0) late_valid = 1'b1;
        end
        total++; if (late_valid) $display("FAIL reset_no_later_valid got=1 exp=0");
        else passed++;
    endtask

    // Full evaluation with hand-computed cycle-by-cycle outputs.
    task automatic test_basic_eval();
        hidden_in = 1'b0;
        result_in = 8'h5A;
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if ({acc_clr, ld, ready, busy, out_valid} !== 5'b10010)
            $display("FAIL clear_cycle got=%b exp=10010", {acc_clr, ld, ready, busy, out_valid});
        else passed++;
        for (int k = 0; k < N; k++) begin
            step();
            total++; if (ld !== 1'b1 || offset !== OW'(k) || acc_clr !== 1'b0 || ready !== 1'b0)
                $display("FAIL acc_cycle_%0d ld=%b off=%0d clr=%b rdy=%b exp ld=1 off=%0d clr=0 rdy=0",
                         k, ld, offset, acc_clr, ready, k);
            else passed++;
        end
        step();
        total++; if (ready !== 1'b1 || ld !== 1'b0 || offset !== OW'(0) || busy !== 1'b1)
            $display("FAIL act_cycle rdy=%b ld=%b off=%0d busy=%b exp 1 0 0 1", ready, ld, offset, busy);
        else passed++;
        step();
        total++; if (out_valid !== 1'b1 || result_out !== 8'h5A || busy !== 1'b0 || ready !== 1'b0)
            $display("FAIL hold_entry valid=%b res=%h busy=%b exp valid=1 res=5a busy=0",
                     out_valid, result_out, busy);
        else passed++;
    endtask

    // HOLD without ack: result is held, start ignored, then ack returns to IDLE.
    task automatic test_hold_stall();
        bit bad;
        bad = 1'b0;
        out_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            result_in = (i % 2 == 1) ? 8'hA5 : 8'h00;
            start = (i % 5 == 2);
            step();
            if (out_valid !== 1'b1 || result_out !== 8'h5A || acc_clr !== 1'b0 || busy !== 1'b0)
                bad = 1'b1;
        end
        start = 1'b0;
        total++; if (bad) $display("FAIL hold_stall valid=%b res=%h clr=%b exp valid=1 res=5a clr=0",
                                   out_valid, result_out, acc_clr);
        else passed++;
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL ack_to_idle valid=%b busy=%b exp 0 0", out_valid, busy);
        else passed++;
        step();
        total++; if (busy !== 1'b0 || acc_clr !== 1'b0 || result_out !== 8'h5A)
            $display("FAIL idle_after_ack busy=%b clr=%b res=%h exp 0 0 5a", busy, acc_clr, result_out);
        else passed++;
    endtask

    // Ack and start in the same HOLD cycle go straight to CLEAR.
    task automatic test_back_to_back();
        bit bad;
        hidden_in = 1'b0;
        result_in = 8'h33;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (N + 2) step();
        total++; if (out_valid !== 1'b1 || result_out !== 8'h33 || hidden !== 1'b0)
            $display("FAIL b2b_first valid=%b res=%h hid=%b exp 1 33 0", out_valid, result_out, hidden);
        else passed++;
        out_ack = 1'b1;
        start = 1'b1;
        hidden_in = 1'b1;
        result_in = 8'hC3;
        step();
        out_ack = 1'b0;
        start = 1'b0;
        total++; if (acc_clr !== 1'b1 || hidden !== 1'b1 || out_valid !== 1'b0 ||
                     result_out !== 8'h33 || busy !== 1'b1)
            $display("FAIL b2b_clear clr=%b hid=%b valid=%b res=%h busy=%b exp 1 1 0 33 1",
                     acc_clr, hidden, out_valid, result_out, busy);
        else passed++;
        bad = 1'b0;
        for (int e = 1; e <= N + 1; e++) begin
            step();
            if (out_valid !== 1'b0) bad = 1'b1;
            if (int'(acc_clr) + int'(ld) + int'(ready) != 1) bad = 1'b1;
        end
        total++; if (bad) $display("FAIL b2b_busy_phase valid/one-hot violated got=1 exp=0");
        else passed++;
        step();
        total++; if (out_valid !== 1'b1 || result_out !== 8'hC3 || hidden !== 1'b1)
            $display("FAIL b2b_second valid=%b res=%h hid=%b exp 1 c3 1", out_valid, result_out, hidden);
        else passed++;
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
    endtask

    // hidden_in toggling mid-run does not disturb the latched layer type.
    task automatic test_hidden_latch();
        bit bad;
        hidden_in = 1'b0;
        result_in = 8'h7E;
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (hidden !== 1'b0) $display("FAIL hidden_latch_start got=%b exp=0", hidden);
        else passed++;
        bad = 1'b0;
        for (int k = 0; k < N; k++) begin
            hidden_in = ~hidden_in;
            step();
            if (hidden !== 1'b0) bad = 1'b1;
        end
        hidden_in = 1'b1;
        step();
        step();
        if (hidden !== 1'b0) bad = 1'b1;
        total++; if (bad || out_valid !== 1'b1 || result_out !== 8'h7E)
            $display("FAIL hidden_latch hid=%b valid=%b res=%h exp 0 1 7e", hidden, out_valid, result_out);
        else passed++;
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
    endtask

    // start and out_ack held high: one result every N+3 cycles.
    task automatic test_throughput();
        int hits[$];
        bit bad;
        out_ack = 1'b1;
        start = 1'b1;
        result_in = 8'h11;
        bad = 1'b0;
        for (int c = 0; c < 46; c++) begin
            step();
            if (out_valid === 1'b1) hits.push_back(c);
            if (busy === 1'b1 && (int'(acc_clr) + int'(ld) + int'(ready) != 1)) bad = 1'b1;
        end
        start = 1'b0;
        total++; if (hits.size() != 3)
            $display("FAIL tput_count got=%0d exp=3", hits.size());
        else passed++;
        total++; if (hits.size() != 3 || hits[0] != int'(N + 2) || hits[1] != int'(2 * N + 5) ||
                     hits[2] != int'(3 * N + 8))
            $display("FAIL tput_spacing first=%0d exp=%0d period N+3=%0d", 
                     (hits.size() > 0) ? hits[0] : -1, N + 2, N + 3);
        else passed++;
        total++; if (bad) $display("FAIL tput_one_hot got=violation exp=exactly one strobe");
        else passed++;
        repeat (N + 6) step();
        out_ack = 1'b0;
        total++; if (busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL tput_drain busy=%b valid=%b exp 0 0", busy, out_valid);
        else passed++;
    endtask

`ifdef NEURON_CTRL_ABORT_EN
    // Abort at offset 4 returns to IDLE; a fresh start then completes.
    task automatic test_abort();
        bit bad;
        result_in = 8'h99;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        total++; if (offset !== OW'(4) || ld !== 1'b1)
            $display("FAIL abort_pre off=%0d ld=%b exp 4 1", offset, ld);
        else passed++;
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++; if (ld !== 1'b0 || offset !== OW'(0) || busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL abort_idle ld=%b off=%0d busy=%b valid=%b exp 0 0 0 0",
                     ld, offset, busy, out_valid);
        else passed++;
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        total++; if (bad || result_out !== 8'h11)
            $display("FAIL abort_no_valid res=%h exp=11", result_out);
        else passed++;
        result_in = 8'h66;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (N + 2) step();
        total++; if (out_valid !== 1'b1 || result_out !== 8'h66)
            $display("FAIL abort_restart valid=%b res=%h exp 1 66", out_valid, result_out);
        else passed++;
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        passed    = 0;
        total     = 0;
        rst       = 1'b1;
`ifdef NEURON_CTRL_ABORT_EN
        abort     = 1'b0;
`endif
        start     = 1'b0;
        hidden_in = 1'b0;
        result_in = '0;
        out_ack   = 1'b0;

        test_reset();
        test_reset_mid_acc();
        test_basic_eval();
        test_hold_stall();
        test_back_to_back();
        test_hidden_latch();
        test_throughput();
`ifdef NEURON_CTRL_ABORT_EN
        test_abort();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
